// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // ST_DATA covers both the wait cycles and the completing cycle of a
  // legal transfer; ST_ERR1/ST_ERR2 are the two cycles of an ERROR reply.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_t;

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// Little-endian byte-lane decode for a 32-bit AHB data bus.
// Unsupported sizes give an empty mask and are flagged as misaligned.
module ahb_byte_lanes
  import ahb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] hsize,
  output logic [3:0] lane_mask,
  output logic       misaligned
);

  // Map (address low bits, size) to the lanes touched by the beat.
  always_comb begin
    lane_mask  = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        lane_mask = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        lane_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        lane_mask  = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        lane_mask  = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB single-master SRAM slave with grant logic, configurable wait states
// and a two-cycle ERROR reply for out-of-range, oversized or misaligned beats.
//
// Handshake: an address phase is taken on a rising edge where o_hready=1,
// i_hsel=1 and htrans is NONSEQ/SEQ. Its data phase then lasts until the
// next edge with o_hready=1; write data is consumed and read data is valid
// on that completing cycle only. o_hready low means the data phase is
// stretched and the address bus is not sampled.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic               i_hsel,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic [2:0]         i_hsize,
  input  logic [2:0]         i_hburst,
  input  logic               i_hwrite,
  input  logic [31:0]        i_hwdata,
  input  logic               i_hbusreq,
  output logic               o_hgrant,
  output logic [31:0]        o_hrdata,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output sram_state_t        o_state
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH_WORDS];

  sram_state_t      state;
  logic [3:0]       wait_cnt;
  logic             hgrant_q;
  logic             hready_q;
  hresp_t           hresp_q;
  logic [31:0]      hrdata_q;

  // Registered copy of the accepted address phase.
  logic [1:0]       p_addr_lo;
  logic [2:0]       p_size;
  logic             p_write;
  logic             p_legal;
  logic [IDX_W-1:0] p_idx;

  logic [31:0]      offset;
  logic [IDX_W-1:0] a_idx;
  logic [3:0]       a_mask;
  logic             a_misaligned;
  logic             a_legal;
  logic             accept;
  logic [3:0]       p_mask;
  logic             p_misaligned;
  logic             wr_now;
  logic [31:0]      rd_word;
  logic [31:0]      p_word;
  logic             unused_ok;

  // Lane decode for the incoming address phase (alignment check).
  ahb_byte_lanes u_addr_lanes (
    .addr_lo    (i_haddr[1:0]),
    .hsize      (i_hsize),
    .lane_mask  (a_mask),
    .misaligned (a_misaligned)
  );

  // Lane decode for the pending data phase (write enables).
  ahb_byte_lanes u_data_lanes (
    .addr_lo    (p_addr_lo),
    .hsize      (p_size),
    .lane_mask  (p_mask),
    .misaligned (p_misaligned)
  );

  // Offset is unsigned: addresses below BASE_ADDR wrap to huge values
  // and fall out of range naturally.
  assign offset  = i_haddr - BASE_ADDR;
  assign a_idx   = offset[IDX_W+1:2];
  assign accept  = hready_q & i_hsel & htrans_active(i_htrans);
  assign a_legal = (offset < SPAN) && (i_hsize <= HSIZE_WORD) && !a_misaligned;

  // A write lands on the edge that completes its data phase.
  assign wr_now  = (state == ST_DATA) && hready_q && p_write && p_legal;
  assign p_word  = mem[p_idx];

  assign unused_ok = ^{i_hburst, a_mask, p_misaligned};

  // Array word for a newly accepted read, with lanes of a write completing
  // on the same edge forwarded from the write bus.
  always_comb begin
    rd_word = mem[a_idx];
    if (wr_now && (p_idx == a_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (p_mask[b]) rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
      end
    end
  end

  // Storage update; no reset so contents survive a bus reset.
  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_now && p_mask[b]) mem[p_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
    end
  end

  // Transfer FSM with grant and all bus outputs registered.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      hgrant_q  <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      hrdata_q  <= 32'd0;
      p_addr_lo <= 2'd0;
      p_size    <= HSIZE_BYTE;
      p_write   <= 1'b0;
      p_legal   <= 1'b0;
      p_idx     <= '0;
    end else begin
      // Grant follows the request, but stays up while a data phase is open.
      hgrant_q <= i_hbusreq | accept | ((state == ST_DATA) && !hready_q) |
                  (state == ST_ERR1);

      if (state == ST_ERR1) begin
        state    <= ST_ERR2;
        hready_q <= 1'b1;
        hresp_q  <= HRESP_ERROR;
      end else if ((state == ST_DATA) && !hready_q) begin
        // Stretched data phase: release on the last wait cycle.
        if (wait_cnt <= 4'd1) begin
          hready_q <= 1'b1;
          if (!p_write) hrdata_q <= p_word;
        end
        wait_cnt <= wait_cnt - 4'd1;
      end else begin
        // o_hready is high here: IDLE, ERR2 or a completing DATA cycle,
        // so a new address phase may be taken on this edge.
        if (accept) begin
          p_addr_lo <= i_haddr[1:0];
          p_size    <= i_hsize;
          p_write   <= i_hwrite;
          p_legal   <= a_legal;
          p_idx     <= a_idx;
        end
        if (accept && a_legal) begin
          state    <= ST_DATA;
          wait_cnt <= WAIT_INIT;
          hready_q <= (WAIT_INIT == 4'd0);
          hresp_q  <= HRESP_OKAY;
          if (!i_hwrite && (WAIT_INIT == 4'd0)) hrdata_q <= rd_word;
        end else if (accept) begin
          state    <= ST_ERR1;
          wait_cnt <= 4'd0;
          hready_q <= 1'b0;
          hresp_q  <= HRESP_ERROR;
        end else begin
          state    <= ST_IDLE;
          wait_cnt <= 4'd0;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
      end
    end
  end

  assign o_hgrant = hgrant_q;
  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;
  assign o_hrdata = hrdata_q;
  assign o_state  = state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance driven
// by a pipelined master engine fed from vector tables.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [2];
  logic        hsel    [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic [2:0]  hsize   [2];
  logic [2:0]  hburst  [2];
  logic        hwrite  [2];
  logic [31:0] hwdata  [2];
  logic        hbusreq [2];
  logic        hgrant  [2];
  logic [31:0] hrdata  [2];
  logic        hready  [2];
  logic [1:0]  hresp   [2];
  sram_state_t dbg_state [2];

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n[0]), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_htrans(htrans[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]),
    .i_hwrite(hwrite[0]), .i_hwdata(hwdata[0]), .i_hbusreq(hbusreq[0]),
    .o_hgrant(hgrant[0]), .o_hrdata(hrdata[0]), .o_hready(hready[0]),
    .o_hresp(hresp[0]), .o_state(dbg_state[0])
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n[1]), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_htrans(htrans[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]),
    .i_hwrite(hwrite[1]), .i_hwdata(hwdata[1]), .i_hbusreq(hbusreq[1]),
    .o_hgrant(hgrant[1]), .o_hrdata(hrdata[1]), .o_hready(hready[1]),
    .o_hresp(hresp[1]), .o_state(dbg_state[1])
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vec[$];
  // {error expected, is read, read data}
  logic [33:0] exp_q[$];

  int checks = 0;
  int fails  = 0;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;

  function automatic vec_t mk(input logic sel, input logic [1:0] trans,
                              input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.write = wr; v.addr = addr;
    v.size = size; v.wdata = wdata; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
    hwrite[d] = 1'b0;
    haddr[d]  = 32'h0;
    hsize[d]  = HSIZE_WORD;
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("rst_hready%0d", d), 32'(hready[d]), 32'd1);
    check($sformatf("rst_hresp%0d", d), 32'(hresp[d]), 32'd0);
    check($sformatf("rst_hgrant%0d", d), 32'(hgrant[d]), 32'd0);
    check($sformatf("rst_hrdata%0d", d), hrdata[d], 32'd0);
    check($sformatf("rst_state%0d", d), 32'(dbg_state[d]), 32'(ST_IDLE));
  endtask

  // Pipelined master: one address phase per ready cycle, data phase on the
  // following cycle(s); completions are scored against exp_q.
  task automatic run_vec(input int d, input int waits);
    int i;
    int guard;
    int wcnt;
    bit dp_valid;
    bit idle_chk;
    logic [31:0] dp_wdata;
    logic [33:0] e;
    vec_t v;
    logic rdy;
    i = 0; guard = 0; wcnt = 0; dp_valid = 0; idle_chk = 0; dp_wdata = '0;
    while ((i < vec.size() || dp_valid || idle_chk) && guard < 500) begin
      @(negedge clk);
      guard++;
      rdy = hready[d];
      if (idle_chk) begin
        check("idle_ready", 32'(hready[d]), 32'd1);
        check("idle_resp", 32'(hresp[d]), 32'd0);
        idle_chk = 0;
      end
      if (dp_valid) begin
        hwdata[d] = dp_wdata;
        e = exp_q[0];
        if (!rdy) begin
          wcnt++;
          check("wait_grant", 32'(hgrant[d]), 32'd1);
          check(e[33] ? "err1_resp" : "wait_resp", 32'(hresp[d]), {31'd0, e[33]});
        end else begin
          e = exp_q.pop_front();
          check("resp", 32'(hresp[d]), {31'd0, e[33]});
          check("wait_cycles", 32'(wcnt), e[33] ? 32'd1 : 32'(waits));
          if (!e[33] && e[32]) check("rdata", hrdata[d], e[31:0]);
          dp_valid = 0;
        end
      end
      if (rdy) begin
        if (i < vec.size()) begin
          v = vec[i];
          i++;
          hsel[d] = v.sel; htrans[d] = v.trans; hwrite[d] = v.write;
          haddr[d] = v.addr; hsize[d] = v.size;
          if (v.sel && v.trans[1]) begin
            exp_q.push_back({v.exp_err, ~v.write, v.exp_rdata});
            dp_valid = 1;
            dp_wdata = v.wdata;
            wcnt = 0;
          end else begin
            idle_chk = 1;
          end
        end else begin
          drive_idle(d);
        end
      end
    end
    if (guard >= 500) begin
      checks++;
      fails++;
      $display("FAIL run_vec_timeout: dut %0d still busy after %0d cycles, required completion", d, guard);
      exp_q.delete();
    end
    drive_idle(d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drive_idle(d);
      hburst[d]  = 3'd0;
      hwdata[d]  = 32'h0;
      hbusreq[d] = 1'b1;   // requested during reset: grant must stay low
    end

    // Reset values held throughout reset.
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs(0);
      check_reset_outputs(1);
    end
    @(negedge clk);
    hbusreq[0] = 1'b0;
    hbusreq[1] = 1'b0;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Grant: one cycle of latency from request.
    @(negedge clk);
    hbusreq[0] = 1'b1;
    check("grant_before", 32'(hgrant[0]), 32'd0);
    @(negedge clk);
    check("grant_after_1", 32'(hgrant[0]), 32'd1);
    hbusreq[0] = 1'b0;
    @(negedge clk);
    check("grant_drop", 32'(hgrant[0]), 32'd0);

    // Zero-wait table: forwarding, partial writes, errors, idle/unselected.
    vec.delete();
    vec.push_back(mk(1, NS, WR, 32'h8000_0000, HSIZE_WORD, 32'hF0FF_0FAA, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0000, HSIZE_WORD, 32'h0,        0, 32'hF0FF_0FAA));
    vec.push_back(mk(1, NS, WR, 32'h8000_0002, HSIZE_HALF, 32'hF0FF_1234, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0000, HSIZE_WORD, 32'h0,        0, 32'hF0FF_0FAA));
    vec.push_back(mk(1, NS, WR, 32'h8000_0002, HSIZE_HALF, 32'hBEEF_5678, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0000, HSIZE_WORD, 32'h0,        0, 32'hBEEF_0FAA));
    vec.push_back(mk(1, NS, WR, 32'h8000_0004, HSIZE_WORD, 32'hA5A5_A5A5, 0, 32'h0));
    vec.push_back(mk(1, NS, WR, 32'h8000_0005, HSIZE_BYTE, 32'h7766_3344, 0, 32'h0));
    vec.push_back(mk(1, NS, WR, 32'h8000_0007, HSIZE_BYTE, 32'hC300_0000, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0004, HSIZE_WORD, 32'h0,        0, 32'hC3A5_33A5));
    vec.push_back(mk(1, SQ, RD, 32'h8000_0005, HSIZE_BYTE, 32'h0,        0, 32'hC3A5_33A5));
    vec.push_back(mk(1, NS, RD, 32'h8000_1000, HSIZE_WORD, 32'h0,        1, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0001, HSIZE_HALF, 32'h0,        1, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0000, 3'd3,       32'h0,        1, 32'h0));
    vec.push_back(mk(1, NS, WR, 32'h8000_1000, HSIZE_WORD, 32'hDEAD_BEEF, 1, 32'h0));
    vec.push_back(mk(1, NS, WR, 32'h8000_0001, HSIZE_HALF, 32'hFFFF_FFFF, 1, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0000, HSIZE_WORD, 32'h0,        0, 32'hBEEF_0FAA));
    vec.push_back(mk(1, NS, WR, 32'h8000_0FFC, HSIZE_WORD, 32'h0BAD_F00D, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0FFC, HSIZE_WORD, 32'h0,        0, 32'h0BAD_F00D));
    vec.push_back(mk(1, NS, RD, 32'h7FFF_FFFC, HSIZE_WORD, 32'h0,        1, 32'h0));
    vec.push_back(mk(0, NS, WR, 32'h8000_0004, HSIZE_WORD, 32'h1234_5678, 0, 32'h0));
    vec.push_back(mk(1, HTRANS_IDLE, WR, 32'h8000_0004, HSIZE_WORD, 32'h1234_5678, 0, 32'h0));
    vec.push_back(mk(1, HTRANS_BUSY, WR, 32'h8000_0004, HSIZE_WORD, 32'h1234_5678, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0004, HSIZE_WORD, 32'h0,        0, 32'hC3A5_33A5));
    vec.push_back(mk(1, NS, WR, 32'h8000_0000, HSIZE_HALF, 32'h1234_ABCD, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0003, HSIZE_BYTE, 32'h0,        0, 32'hBEEF_ABCD));
    run_vec(0, 0);

    // Three-wait instance: stretched writes/reads and an error beat.
    vec.delete();
    vec.push_back(mk(1, NS, WR, 32'h8000_0010, HSIZE_WORD, 32'h1357_9BDF, 0, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0010, HSIZE_WORD, 32'h0,        0, 32'h1357_9BDF));
    vec.push_back(mk(1, NS, WR, 32'h8000_0014, HSIZE_WORD, 32'h2468_ACE0, 0, 32'h0));
    vec.push_back(mk(1, SQ, RD, 32'h8000_0014, HSIZE_WORD, 32'h0,        0, 32'h2468_ACE0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0010, 3'd3,       32'h0,        1, 32'h0));
    vec.push_back(mk(1, NS, RD, 32'h8000_0010, HSIZE_WORD, 32'h0,        0, 32'h1357_9BDF));
    run_vec(1, 3);

    // Reset in the middle of a three-wait write: outputs drop at once and
    // the write never reaches the array.
    @(negedge clk);
    check("pre_write_ready", 32'(hready[1]), 32'd1);
    hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1'b1;
    haddr[1] = 32'h8000_0014; hsize[1] = HSIZE_WORD;
    @(negedge clk);
    drive_idle(1);
    hwdata[1] = 32'hFFFF_FFFF;
    check("mid_write_wait", 32'(hready[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    check_reset_outputs(1);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    vec.delete();
    vec.push_back(mk(1, NS, RD, 32'h8000_0014, HSIZE_WORD, 32'h0, 0, 32'h2468_ACE0));
    run_vec(1, 3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
